// File: rtl/mem_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_responder
//  Description : Single-bank memory-bus slave. Accepts one read or write
//                request at a time, inserts a programmable number of wait
//                states, then completes with a one-cycle acknowledge. Requests
//                addressed to another bank still complete, but are flagged
//                as a bank miss and leave the backing store untouched.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_bus_responder #(
    parameter logic [3:0] BANK        = 4'd1,
    parameter int         DEPTH_LOG2  = 10,
    parameter int         WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic        i_write,
    input  logic [3:0]  i_bank,
    input  logic [23:0] i_address,
    input  logic [31:0] i_data,
    output logic        o_busy,
    output logic        o_ack,
    output logic [31:0] o_data,
    output logic        o_bank_miss
);

    // Wait-state count as loaded into the 4-bit counter on accept.
    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam int         c_DEPTH     = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [3:0]              r_wait_cnt;
    logic [3:0]              w_next_wait_cnt;

    // Strobes from the FSM: request taken this edge / memory access this edge.
    logic                    w_accept;
    logic                    w_complete;

    // Transfer attributes captured at accept.
    logic                    r_write;
    logic [3:0]              r_bank;
    logic [DEPTH_LOG2-1:0]   r_index;
    logic [31:0]             r_wdata;
    logic                    r_miss;

    // Attributes of the transfer being completed. With zero wait states the
    // access happens on the accepting edge itself, before the capture
    // registers hold the request, so the live inputs are used in IDLE.
    logic                    w_op_write;
    logic [3:0]              w_op_bank;
    logic [DEPTH_LOG2-1:0]   w_op_index;
    logic [31:0]             w_op_wdata;
    logic                    w_op_hit;
    logic                    w_mem_we;

    logic [31:0]             r_mem [0:c_DEPTH-1];

    // Byte-lane bits and address bits above the store size play no part.
    logic                    w_unused_addr_bits;
    assign w_unused_addr_bits = &{i_address[1:0], i_address[23:DEPTH_LOG2+2]};

    // State register and wait counter; reset aborts any transfer in flight.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait_cnt;
        end
    end

    // Next-state logic: IDLE -> (WAIT x WAIT_CYCLES) -> ACK -> IDLE.
    always_comb begin
        w_next_state    = r_state;
        w_next_wait_cnt = r_wait_cnt;
        w_accept        = 1'b0;
        w_complete      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_request) begin
                    w_accept = 1'b1;
                    if (c_WAIT_LOAD == 4'd0) begin
                        // No wait states: access now, acknowledge next cycle.
                        w_complete      = 1'b1;
                        w_next_state    = ST_ACK;
                        w_next_wait_cnt = 4'd0;
                    end else begin
                        w_next_state    = ST_WAIT;
                        w_next_wait_cnt = c_WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                // Leave WAIT on the edge where the counter runs out.
                if (r_wait_cnt <= 4'd1) begin
                    w_complete      = 1'b1;
                    w_next_state    = ST_ACK;
                    w_next_wait_cnt = 4'd0;
                end else begin
                    w_next_wait_cnt = r_wait_cnt - 4'd1;
                end
            end
            ST_ACK: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state    = ST_IDLE;
                w_next_wait_cnt = 4'd0;
            end
        endcase
    end

    // Select live or captured request attributes for the completing access.
    always_comb begin
        w_op_write = r_write;
        w_op_bank  = r_bank;
        w_op_index = r_index;
        w_op_wdata = r_wdata;
        if (r_state == ST_IDLE) begin
            w_op_write = i_write;
            w_op_bank  = i_bank;
            w_op_index = i_address[DEPTH_LOG2+1:2];
            w_op_wdata = i_data;
        end
    end

    assign w_op_hit = (w_op_bank == BANK);
    // Reset gating keeps an edge coinciding with reset from touching the store.
    assign w_mem_we = w_complete & w_op_write & w_op_hit & ~i_reset;

    // Capture the request on accept; later input changes are ignored.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_write <= 1'b0;
            r_bank  <= 4'd0;
            r_index <= '0;
            r_wdata <= 32'h0000_0000;
        end else if (w_accept) begin
            r_write <= i_write;
            r_bank  <= i_bank;
            r_index <= i_address[DEPTH_LOG2+1:2];
            r_wdata <= i_data;
        end
    end

    // Bank-miss flag for the acknowledge cycle, set when the access happens.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_miss <= 1'b0;
        end else if (w_complete) begin
            r_miss <= ~w_op_hit;
        end
    end

    // Backing store write port; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[w_op_index] <= w_op_wdata;
        end
    end

    // Registered read data: store word on a hit, zero on a miss, held on writes.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_data <= 32'h0000_0000;
        end else if (w_complete && !w_op_write) begin
            o_data <= w_op_hit ? r_mem[w_op_index] : 32'h0000_0000;
        end
    end

    assign o_busy      = (r_state != ST_IDLE);
    assign o_ack       = (r_state == ST_ACK);
    assign o_bank_miss = (r_state == ST_ACK) & r_miss;

endmodule
`default_nettype wire
